// File: rtl/dt_pkg.sv
// dt_pkg
//   Shared definitions for the decision-tree front end: channel tags,
//   channel count, framer state encoding and the default sample/class
//   widths used by both the sample framer and the classifier.
//   No ports (package).

package dt_pkg;

    // Default sample width and class-index width shared with the classifier.
    localparam int DT_N = 8;
    localparam int DT_C = 3;

    // Number of channels in one aligned frame.
    localparam int NCH = 6;

    // Channel tags carried on s_chan. Tags 6 and 7 are illegal.
    typedef enum logic [2:0] {
        CH_VA = 3'd0,
        CH_VB = 3'd1,
        CH_VC = 3'd2,
        CH_IA = 3'd3,
        CH_IB = 3'd4,
        CH_IC = 3'd5
    } ch_e;

    // Framer states: COLLECT accepts beats, PEND holds a complete frame
    // in staging while the output slot is still occupied.
    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_PEND    = 1'b1
    } state_e;

endpackage

// File: rtl/dt_frame_reg.sv
// dt_frame_reg
//   Single-entry valid/ready output holding register for a full frame.
//   Ports:
//     clk, rst_n  - clock, synchronous active-low reset
//     load        - capture din this cycle (only when slot_free)
//     din         - frame to capture (W bits)
//     m_ready     - downstream takes the held frame
//     m_valid     - held frame is valid
//     dout        - held frame (stable while m_valid && !m_ready)
//     slot_free   - register may be overwritten this cycle

module dt_frame_reg #(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         m_ready,
    output logic         m_valid,
    output logic [W-1:0] dout,
    output logic         slot_free
);

    // The slot can be refilled either when empty or when the current
    // frame is being consumed in this same cycle.
    assign slot_free = !m_valid || m_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            dout    <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            dout    <= din;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dt_sample_framer.sv
// dt_sample_framer
//   Collects six channel-tagged sample beats (Va, Vb, Vc, Ia, Ib, Ic) in
//   strict order into staging registers and presents the aligned frame to
//   the decision-tree classifier through a valid/ready output slot.
//   Out-of-order or illegal tags raise a one-cycle frame_err pulse; a tag of
//   0 resynchronises on the spot, anything else drops back to channel 0.
//   Ports:
//     clk, rst_n        - clock, synchronous active-low reset
//     s_valid/s_ready   - upstream beat handshake
//     s_data, s_chan    - sample value and channel tag
//     Va..Ic            - aligned frame outputs
//     m_valid/m_ready   - frame handshake towards the classifier
//     frame_err         - one-cycle pulse on a sequence error
//     frame_cnt         - delivered-frame counter, wraps modulo 2^CW

module dt_sample_framer
    import dt_pkg::*;
#(
    parameter int N  = DT_N,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [N-1:0]  s_data,
    input  logic [2:0]    s_chan,
    output logic [N-1:0]  Va,
    output logic [N-1:0]  Vb,
    output logic [N-1:0]  Vc,
    output logic [N-1:0]  Ia,
    output logic [N-1:0]  Ib,
    output logic [N-1:0]  Ic,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          frame_err,
    output logic [CW-1:0] frame_cnt
);

    state_e             state;
    logic [2:0]         idx;
    logic [N-1:0]       stg [NCH];

    logic               accept;
    logic               in_order;
    logic               last_beat;
    logic               slot_free;
    logic               load;
    logic [NCH*N-1:0]   load_data;
    logic [NCH*N-1:0]   frame_q;

    // Gating with rst_n keeps s_ready low while reset is held.
    assign s_ready   = rst_n && (state == ST_COLLECT);
    assign accept    = s_valid && s_ready;
    assign in_order  = (s_chan == idx);
    assign last_beat = (idx == CH_IC);

    // A frame enters the output slot either straight from the last beat
    // (staging plus live s_data) or from staging when leaving PEND.
    always_comb begin
        load      = 1'b0;
        load_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            load_data[i*N +: N] = stg[i];
        end
        if (state == ST_COLLECT) begin
            if (accept && in_order && last_beat && slot_free) begin
                load = 1'b1;
                load_data[(NCH-1)*N +: N] = s_data;
            end
        end else if (slot_free) begin
            load = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_COLLECT;
            idx       <= '0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                stg[i] <= '0;
            end
        end else begin
            frame_err <= 1'b0;
            if (m_valid && m_ready) begin
                frame_cnt <= frame_cnt + CW'(1);
            end
            case (state)
                ST_COLLECT: begin
                    if (accept) begin
                        if (in_order) begin
                            // The last beat is always written to staging;
                            // it only matters when the frame has to wait in PEND.
                            stg[idx] <= s_data;
                            if (!last_beat) begin
                                idx <= idx + 3'd1;
                            end else if (slot_free) begin
                                idx <= '0;
                            end else begin
                                state <= ST_PEND;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            if (s_chan == CH_VA) begin
                                stg[0] <= s_data;
                                idx    <= 3'd1;
                            end else begin
                                idx <= '0;
                            end
                        end
                    end
                end
                ST_PEND: begin
                    if (slot_free) begin
                        state <= ST_COLLECT;
                        idx   <= '0;
                    end
                end
                default: begin
                    state <= ST_COLLECT;
                    idx   <= '0;
                end
            endcase
        end
    end

    dt_frame_reg #(
        .W (NCH*N)
    ) u_frame_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .din       (load_data),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .dout      (frame_q),
        .slot_free (slot_free)
    );

    assign Va = frame_q[0*N +: N];
    assign Vb = frame_q[1*N +: N];
    assign Vc = frame_q[2*N +: N];
    assign Ia = frame_q[3*N +: N];
    assign Ib = frame_q[4*N +: N];
    assign Ic = frame_q[5*N +: N];

endmodule

// File: tb/tb_dt_sample_framer.sv
// tb_dt_sample_framer
//   Self-checking bench for dt_sample_framer (N=8, CW=4).

module tb_dt_sample_framer;
    import dt_pkg::*;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [N-1:0]  s_data = '0;
    logic [2:0]    s_chan = '0;
    logic [N-1:0]  Va, Vb, Vc, Ia, Ib, Ic;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          frame_err;
    logic [CW-1:0] frame_cnt;

    always #5 clk = ~clk;

    dt_sample_framer #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_chan    (s_chan),
        .Va        (Va),
        .Vb        (Vb),
        .Vc        (Vc),
        .Ia        (Ia),
        .Ib        (Ib),
        .Ic        (Ic),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    int chk = 0;
    int passed = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef logic [6*N-1:0] frame_t;
    frame_t       exp_q[$];
    int           midx = 0;
    logic [N-1:0] mstg [6];
    int           err_exp = 0;
    int           err_seen = 0;
    int           delivered = 0;
    int           exp_cnt = 0;
    logic [N-1:0] last_va = '0;
    logic [N-1:0] last_ic = '0;
    frame_t       got_f, exp_f;

    task automatic model_accept(input logic [2:0] ch, input logic [N-1:0] d);
        if (int'(ch) == midx) begin
            mstg[midx] = d;
            if (midx == 5) begin
                exp_q.push_back({mstg[5], mstg[4], mstg[3], mstg[2], mstg[1], mstg[0]});
                midx = 0;
            end else begin
                midx++;
            end
        end else begin
            err_exp++;
            if (ch == 3'd0) begin
                mstg[0] = d;
                midx = 1;
            end else begin
                midx = 0;
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        midx = 0;
        exp_cnt = 0;
        for (int i = 0; i < 6; i++) mstg[i] = '0;
    endtask

    // Monitor samples mid-cycle: a handshake seen here completes at the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) err_seen++;
            if (m_valid && m_ready) begin
                got_f = {Ic, Ib, Ia, Vc, Vb, Va};
                if (exp_q.size() == 0) begin
                    chk++;
                    $display("FAIL unexpected_frame: got frame %h expected none", got_f);
                end else begin
                    exp_f = exp_q.pop_front();
                    check("frame_data", 64'(got_f), 64'(exp_f));
                end
                check("frame_cnt_run", 64'(frame_cnt), 64'(exp_cnt));
                exp_cnt = (exp_cnt + 1) % 16;
                delivered++;
                last_va = Va;
                last_ic = Ic;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after acceptance.
    task automatic beat(input logic [2:0] ch, input logic [N-1:0] d);
        bit ok;
        ok = 0;
        s_valid = 1'b1;
        s_chan  = ch;
        s_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            chk++;
            $display("FAIL beat_timeout: ch %0d not accepted within 50 cycles", ch);
        end else begin
            model_accept(ch, d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]   ch;
        logic [N-1:0] data;
        logic         exp_err;
        logic         exp_mv;
        bit           grp_end;
        int           exp_cnt;
        logic [N-1:0] exp_va;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(input int ch, input int d, input bit e, input bit mv,
                                input bit ge, input int cnt, input int va);
        vec_t v;
        v.ch = 3'(ch); v.data = N'(d); v.exp_err = e; v.exp_mv = mv;
        v.grp_end = ge; v.exp_cnt = cnt; v.exp_va = N'(va);
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, e0, d0;

        // in-order frame
        tbl[0]  = mk(0, 10, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 20, 0, 0, 0, 0, 0);
        tbl[2]  = mk(2, 30, 0, 0, 0, 0, 0);
        tbl[3]  = mk(3, 40, 0, 0, 0, 0, 0);
        tbl[4]  = mk(4, 50, 0, 0, 0, 0, 0);
        tbl[5]  = mk(5, 60, 0, 1, 1, 1, 10);
        // skip error then clean frame
        tbl[6]  = mk(0, 1, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 2, 0, 0, 0, 0, 0);
        tbl[8]  = mk(3, 3, 1, 0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 0, 0, 0, 0, 0);
        tbl[10] = mk(1, 2, 0, 0, 0, 0, 0);
        tbl[11] = mk(2, 3, 0, 0, 0, 0, 0);
        tbl[12] = mk(3, 4, 0, 0, 0, 0, 0);
        tbl[13] = mk(4, 5, 0, 0, 0, 0, 0);
        tbl[14] = mk(5, 6, 0, 1, 1, 2, 1);
        // resync on ch0
        tbl[15] = mk(0, 7, 0, 0, 0, 0, 0);
        tbl[16] = mk(1, 8, 0, 0, 0, 0, 0);
        tbl[17] = mk(0, 99, 1, 0, 0, 0, 0);
        tbl[18] = mk(1, 8, 0, 0, 0, 0, 0);
        tbl[19] = mk(2, 9, 0, 0, 0, 0, 0);
        tbl[20] = mk(3, 10, 0, 0, 0, 0, 0);
        tbl[21] = mk(4, 11, 0, 0, 0, 0, 0);
        tbl[22] = mk(5, 12, 0, 1, 1, 3, 99);

        model_reset();
        m_ready = 1'b1;

        // reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 64'(s_ready), 0);
        check("rst_m_valid", 64'(m_valid), 0);
        check("rst_frame_err", 64'(frame_err), 0);
        check("rst_frame_cnt", 64'(frame_cnt), 0);
        check("rst_Va", 64'(Va), 0);
        check("rst_Ic", 64'(Ic), 0);
        rst_n = 1'b1;
        #1;
        check("s_ready_after_rst", 64'(s_ready), 1);
        @(posedge clk);
        #1;

        // table-driven section
        for (int i = 0; i < 23; i++) begin
            beat(tbl[i].ch, tbl[i].data);
            check("row_frame_err", 64'(frame_err), 64'(tbl[i].exp_err));
            check("row_m_valid", 64'(m_valid), 64'(tbl[i].exp_mv));
            if (tbl[i].grp_end) begin
                idle(2);
                check("grp_frame_cnt", 64'(frame_cnt), 64'(tbl[i].exp_cnt));
                check("grp_Va", 64'(last_va), 64'(tbl[i].exp_va));
            end
        end
        check("first_frame_Ic_60", 64'(tbl[5].data), 64'(60));

        // back-to-back throughput: 12 beats in 12 cycles
        c0 = cyc;
        for (int f = 0; f < 2; f++)
            for (int ch = 0; ch < 6; ch++)
                beat(3'(ch), N'(100 + 10*f + ch));
        check("throughput_cycles", 64'(cyc - c0), 12);
        idle(2);
        check("tp_frame_cnt", 64'(frame_cnt), 5);
        check("tp_last_Ic", 64'(last_ic), 115);

        // backpressure and PEND
        m_ready = 1'b0;
        for (int ch = 0; ch < 6; ch++) beat(3'(ch), N'(21 + ch));
        check("bp_m_valid", 64'(m_valid), 1);
        check("bp_Va_A", 64'(Va), 21);
        for (int ch = 0; ch < 5; ch++) beat(3'(ch), N'(31 + ch));
        idle(3);
        check("bp_hold_Va", 64'(Va), 21);
        check("bp_hold_Ic", 64'(Ic), 26);
        beat(3'd5, N'(36));
        check("pend_s_ready", 64'(s_ready), 0);
        idle(3);
        check("pend_s_ready_hold", 64'(s_ready), 0);
        check("pend_Va_hold", 64'(Va), 21);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        check("pend_B_Va", 64'(Va), 31);
        check("pend_B_valid", 64'(m_valid), 1);
        check("pend_exit_s_ready", 64'(s_ready), 1);
        idle(2);
        check("bp_frame_cnt", 64'(frame_cnt), 7);

        // reset mid-frame
        for (int ch = 0; ch < 4; ch++) beat(3'(ch), N'(41 + ch));
        e0 = err_seen;
        rst_n = 1'b0;
        model_reset();
        idle(2);
        check("mid_rst_s_ready", 64'(s_ready), 0);
        check("mid_rst_err", 64'(frame_err), 0);
        check("mid_rst_cnt", 64'(frame_cnt), 0);
        check("mid_rst_m_valid", 64'(m_valid), 0);
        rst_n = 1'b1;
        #1;
        check("mid_rst_release_ready", 64'(s_ready), 1);
        d0 = delivered;
        for (int ch = 0; ch < 6; ch++) beat(3'(ch), N'(51 + ch));
        idle(2);
        check("post_rst_frame_cnt", 64'(frame_cnt), 1);
        check("post_rst_Va", 64'(last_va), 51);
        check("post_rst_one_frame", 64'(delivered - d0), 1);
        check("post_rst_no_err", 64'(err_seen - e0), 0);

        // counter wrap: 16 more frames -> 17 total
        for (int f = 0; f < 16; f++)
            for (int ch = 0; ch < 6; ch++)
                beat(3'(ch), N'($urandom_range(0, 255)));
        idle(2);
        check("wrap_frame_cnt", 64'(frame_cnt), 1);

        // illegal tag
        beat(3'd7, N'(8'hAA));
        check("tag7_err", 64'(frame_err), 1);
        idle(1);
        check("tag7_err_pulse_end", 64'(frame_err), 0);

        idle(3);
        check("scoreboard_empty", 64'(exp_q.size()), 0);
        check("err_count", 64'(err_seen), 64'(err_exp));

        $display("%0d/%0d checks passed", passed, chk);
        $finish;
    end

endmodule
